// File: rtl/mxn_pkg.sv
// mxn_pkg: shared constants for the mxn_scan multiplexer.
// Holds the mode encodings and the output-register state encoding.
package mxn_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Output register occupancy; FULL is encoded as 1 so it matches out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } mxn_state_e;

endpackage : mxn_pkg

// File: rtl/mxn_rr_pick.sv
// mxn_rr_pick: combinational rotating-priority finder.
// Returns the first set bit of en_mask at or above ptr, wrapping from NCH-1
// back to 0, plus a hit flag that is set whenever any bit is enabled.
module mxn_rr_pick #(
    parameter int NCH  = 8,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  en_mask,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] found,
    output logic            hit
);

    // Walk offsets from farthest to nearest so the nearest enabled channel wins.
    always_comb begin
        int idx_v;
        idx_v = 0;
        found = {SELW{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            idx_v = (int'(ptr) + i) % NCH;
            if (en_mask[idx_v]) begin
                found = SELW'(idx_v);
            end else begin
                found = found;
            end
        end
    end

    assign hit = |en_mask;

endmodule : mxn_rr_pick

// File: rtl/mxn_scan.sv
// mxn_scan: NCH-channel, WIDTH-bit multiplexer with a registered,
// valid/ready-handshaked output. Direct mode captures channel sel; scan mode
// captures the enabled channels in round-robin order.
// Optional macro MXN_SCAN_PARITY_EN adds the registered even-parity output y_par.
module mxn_scan
    import mxn_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 8,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] d_in,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic [NCH-1:0]       en_mask,
    input  logic                 in_valid,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     y,
    output logic [SELW-1:0]      y_ch
`ifdef MXN_SCAN_PARITY_EN
    ,
    output logic                 y_par
`endif
);

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    mxn_state_e       state_r, state_nxt_s;
    logic [WIDTH-1:0] y_r;
    logic [SELW-1:0]  y_ch_r;
    logic [SELW-1:0]  ptr_r;
    logic             par_r;

    logic [SELW-1:0]  found_s;
    logic             pick_hit_s;
    logic             hit_s;
    logic             cap_s;
    logic [WIDTH-1:0] direct_data_s;
    logic [WIDTH-1:0] scan_data_s;
    logic [WIDTH-1:0] next_data_s;
    logic [SELW-1:0]  next_ch_s;
    logic [SELW-1:0]  ptr_inc_s;

    mxn_rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_pick (
        .en_mask (en_mask),
        .ptr     (ptr_r),
        .found   (found_s),
        .hit     (pick_hit_s)
    );

    // Select the direct and scan candidates; an out-of-range sel yields zero data.
    always_comb begin
        direct_data_s = {WIDTH{1'b0}};
        scan_data_s   = {WIDTH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            if (SELW'(k) == sel) begin
                direct_data_s = d_in[k*WIDTH +: WIDTH];
            end else begin
                direct_data_s = direct_data_s;
            end
            if (SELW'(k) == found_s) begin
                scan_data_s = d_in[k*WIDTH +: WIDTH];
            end else begin
                scan_data_s = scan_data_s;
            end
        end
    end

    // Mode-dependent capture word, capture condition and next scan pointer.
    always_comb begin
        if (mode == MODE_SCAN) begin
            hit_s       = pick_hit_s;
            next_data_s = scan_data_s;
            next_ch_s   = found_s;
        end else begin
            hit_s       = 1'b1;
            next_data_s = direct_data_s;
            next_ch_s   = sel;
        end
        cap_s = in_valid & hit_s & (~state_r | out_ready);
        if (found_s == SELW'(NCH - 1)) begin
            ptr_inc_s = {SELW{1'b0}};
        end else begin
            ptr_inc_s = found_s + SELW'(1);
        end
    end

    // Output-register FSM next state: load on capture, drain on ready, else hold.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (cap_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (cap_s) begin
                    state_nxt_s = ST_FULL;
                end else if (out_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // State, output word and scan pointer registers; pointer moves only on scan captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
            y_r     <= {WIDTH{1'b0}};
            y_ch_r  <= {SELW{1'b0}};
            ptr_r   <= {SELW{1'b0}};
            par_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (cap_s) begin
                y_r    <= next_data_s;
                y_ch_r <= next_ch_s;
                par_r  <= even_parity(next_data_s);
            end
            if (cap_s && (mode == MODE_SCAN)) begin
                ptr_r <= ptr_inc_s;
            end
        end
    end

    assign out_valid = (state_r == ST_FULL);
    assign y         = y_r;
    assign y_ch      = y_ch_r;

`ifdef MXN_SCAN_PARITY_EN
    assign y_par = par_r;
`else
    logic unused_par_s;
    assign unused_par_s = par_r;
`endif

endmodule : mxn_scan
